// File: rtl/alba_pkg.sv
// Shared albaCore widths plus the ram_loader state encoding.
package alba_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;

  // Loading states are numbered 0..7 so "still loading" is a single compare.
  localparam logic [3:0] ST_ADDR_HI = 4'd0;
  localparam logic [3:0] ST_ADDR_LO = 4'd1;
  localparam logic [3:0] ST_CNT_HI  = 4'd2;
  localparam logic [3:0] ST_CNT_LO  = 4'd3;
  localparam logic [3:0] ST_DATA_HI = 4'd4;
  localparam logic [3:0] ST_DATA_LO = 4'd5;
  localparam logic [3:0] ST_SUM_HI  = 4'd6;
  localparam logic [3:0] ST_SUM_LO  = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;
  localparam logic [3:0] ST_ERROR   = 4'd9;

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream, CPU memory port and RAM port seen by the loader.
interface ram_loader_if;
  import alba_pkg::*;

  byte_t rx_data;
  logic  rx_valid;
  logic  rx_ready;
  word_t cpu_addr;
  word_t cpu_din;
  logic  cpu_we;
  word_t ram_addr;
  word_t ram_din;
  logic  ram_we;

  modport master (
    output rx_data, rx_valid, cpu_addr, cpu_din, cpu_we,
    input  rx_ready, ram_addr, ram_din, ram_we
  );

  modport slave (
    input  rx_data, rx_valid, cpu_addr, cpu_din, cpu_we,
    output rx_ready, ram_addr, ram_din, ram_we
  );

endinterface

// File: rtl/ram_loader_byte_to_word.sv
// Holds the most recent high byte and emits a one-cycle registered word
// pulse when the matching low byte arrives.
module byte_to_word
  import alba_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  byte_t byte_in,
  input  logic  hi_en,
  input  logic  lo_en,
  output byte_t hi_byte,
  output word_t word,
  output logic  word_valid
);

  byte_t hi_q, hi_d;
  word_t word_q, word_d;
  logic  valid_q, valid_d;

  always_comb begin
    hi_d    = hi_q;
    word_d  = word_q;
    valid_d = lo_en;
    if (hi_en) hi_d = byte_in;
    if (lo_en) word_d = {hi_q, byte_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign hi_byte    = hi_q;
  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/ram_loader.sv
// Boot loader: parses a framed byte stream into RAM, verifies the checksum,
// then hands the RAM port to the CPU.
module ram_loader
  import alba_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  ram_loader_if.slave bus,
  input  logic load_req,
  output logic cpu_run,
  output logic done,
  output logic err
);

  logic [3:0] state_q, state_d;
  word_t      cnt_q, cnt_d;
  word_t      addr_q, addr_d;
  word_t      sum_q, sum_d;
  word_t      idle_q, idle_d;

  logic  loading, xfer, hi_en, lo_en, word_valid;
  byte_t hi_byte;
  word_t word;

  assign loading = (state_q <= ST_SUM_LO);
  assign xfer    = bus.rx_valid && loading;
  assign hi_en   = xfer && (state_q == ST_ADDR_HI || state_q == ST_CNT_HI ||
                            state_q == ST_DATA_HI || state_q == ST_SUM_HI);
  assign lo_en   = xfer && (state_q == ST_DATA_LO);

  byte_to_word u_b2w (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (bus.rx_data),
    .hi_en      (hi_en),
    .lo_en      (lo_en),
    .hi_byte    (hi_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    idle_d  = '0;

    // The registered write lands one cycle after DATA_LO, overlapping the next byte.
    if (word_valid) begin
      addr_d = addr_q + 16'd1;
      sum_d  = sum_q + word;
    end

    if (loading && state_q != ST_ADDR_HI && !xfer) idle_d = idle_q + 16'd1;

    case (state_q)
      ST_ADDR_HI: if (xfer) begin
        state_d = ST_ADDR_LO;
        sum_d   = '0;
      end
      ST_ADDR_LO: if (xfer) begin
        addr_d  = {hi_byte, bus.rx_data};
        state_d = ST_CNT_HI;
      end
      ST_CNT_HI: if (xfer) state_d = ST_CNT_LO;
      ST_CNT_LO: if (xfer) begin
        cnt_d   = {hi_byte, bus.rx_data};
        state_d = ({hi_byte, bus.rx_data} == 16'd0) ? ST_SUM_HI : ST_DATA_HI;
      end
      ST_DATA_HI: if (xfer) state_d = ST_DATA_LO;
      ST_DATA_LO: if (xfer) begin
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? ST_SUM_HI : ST_DATA_HI;
      end
      ST_SUM_HI: if (xfer) state_d = ST_SUM_LO;
      ST_SUM_LO: if (xfer) begin
        state_d = ({hi_byte, bus.rx_data} == sum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE: if (load_req) state_d = ST_ADDR_HI;
      default: state_d = ST_ERROR;
    endcase

    // Idle watchdog only runs once a frame has started.
    if (TIMEOUT != 16'd0 && loading && state_q != ST_ADDR_HI && !xfer &&
        idle_q == TIMEOUT - 16'd1)
      state_d = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ADDR_HI;
      cnt_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.rx_ready = loading;
  assign cpu_run      = (state_q == ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_ERROR);

  always_comb begin
    if (cpu_run) begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_din  = bus.cpu_din;
      bus.ram_we   = bus.cpu_we;
    end else begin
      bus.ram_addr = addr_q;
      bus.ram_din  = word;
      bus.ram_we   = word_valid;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: frames, checksum error, wrap, empty frame,
// timeout, CPU pass-through and mid-load reset.
module tb_ram_loader;
  import alba_pkg::*;

  logic clk;
  logic rst;
  logic load_req;
  logic cpu_run, done, err;

  int checks;
  int errors;
  int stalls;
  int wr_cnt;
  int base;
  logic [15:0] wr_addr [0:63];
  logic [15:0] wr_data [0:63];

  ram_loader_if bus ();

  ram_loader #(.TIMEOUT(16'd8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .load_req (load_req),
    .cpu_run  (cpu_run),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loader-driven writes are logged away from the active edge.
  initial wr_cnt = 0;
  always @(negedge clk) begin
    if (bus.ram_we && !cpu_run && wr_cnt < 64) begin
      wr_addr[wr_cnt] = bus.ram_addr;
      wr_data[wr_cnt] = bus.ram_din;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    if (!bus.rx_ready) stalls++;
    @(posedge clk);
  endtask

  task automatic endStream();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulseLoad();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] f [], input int n);
    for (int i = 0; i < n; i++) applyStimulus(f[i]);
    endStream();
  endtask

  initial begin
    logic [7:0] f [];
    checks       = 0;
    errors       = 0;
    stalls       = 0;
    rst          = 1'b0;
    load_req     = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_din  = 16'h0000;
    bus.cpu_we   = 1'b0;

    doReset();
    checkOutput("rst_cpu_run", cpu_run, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rx_ready", bus.rx_ready, 1);
    checkOutput("rst_ram_we", bus.ram_we, 0);

    $display("[TB] good two-word frame");
    base = wr_cnt;
    f = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h70, 8'h04, 8'h71, 8'h05, 8'hE1, 8'h09};
    sendFrame(f, 10);
    checkOutput("t1_wr_count", wr_cnt - base, 2);
    checkOutput("t1_wr0_addr", wr_addr[base], 16'h0000);
    checkOutput("t1_wr0_data", wr_data[base], 16'h7004);
    checkOutput("t1_wr1_addr", wr_addr[base+1], 16'h0001);
    checkOutput("t1_wr1_data", wr_data[base+1], 16'h7105);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_cpu_run", cpu_run, 1);
    checkOutput("t1_err", err, 0);
    checkOutput("t1_stalls", stalls, 0);
    checkOutput("t1_rx_ready", bus.rx_ready, 0);

    $display("[TB] CPU pass-through and reload");
    @(negedge clk);
    bus.cpu_addr = 16'h0080;
    bus.cpu_din  = 16'h01FF;
    bus.cpu_we   = 1'b1;
    #1;
    checkOutput("mux_addr", bus.ram_addr, 16'h0080);
    checkOutput("mux_din", bus.ram_din, 16'h01FF);
    checkOutput("mux_we", bus.ram_we, 1);
    bus.cpu_we = 1'b0;
    load_req   = 1'b1;
    #1;
    checkOutput("reload_before_edge", cpu_run, 1);
    @(negedge clk);
    load_req = 1'b0;
    checkOutput("reload_cpu_run", cpu_run, 0);
    checkOutput("reload_done", done, 0);
    checkOutput("reload_rx_ready", bus.rx_ready, 1);

    $display("[TB] bad checksum frame");
    base = wr_cnt;
    f = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h70, 8'h04, 8'h71, 8'h05, 8'hE1, 8'h0A};
    sendFrame(f, 10);
    checkOutput("t2_wr_count", wr_cnt - base, 2);
    checkOutput("t2_wr1_data", wr_data[base+1], 16'h7105);
    checkOutput("t2_err", err, 1);
    checkOutput("t2_cpu_run", cpu_run, 0);
    checkOutput("t2_rx_ready", bus.rx_ready, 0);
    bus.cpu_we = 1'b1;
    #1;
    checkOutput("t2_cpu_we_ignored", bus.ram_we, 0);
    bus.cpu_we = 1'b0;
    pulseLoad();
    @(negedge clk);
    checkOutput("t2_err_sticky", err, 1);
    checkOutput("t2_ready_after_req", bus.rx_ready, 0);
    doReset();
    checkOutput("t2_err_cleared", err, 0);

    $display("[TB] address wrap frame");
    base = wr_cnt;
    f = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h68, 8'hAC};
    sendFrame(f, 10);
    checkOutput("t3_wr_count", wr_cnt - base, 2);
    checkOutput("t3_wr0_addr", wr_addr[base], 16'hFFFF);
    checkOutput("t3_wr0_data", wr_data[base], 16'h1234);
    checkOutput("t3_wr1_addr", wr_addr[base+1], 16'h0000);
    checkOutput("t3_wr1_data", wr_data[base+1], 16'h5678);
    checkOutput("t3_done", done, 1);
    pulseLoad();

    $display("[TB] empty frame");
    base = wr_cnt;
    f = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) applyStimulus(f[i]);
    @(negedge clk);
    checkOutput("t4_done_before_last", done, 0);
    applyStimulus(8'h00);
    endStream();
    checkOutput("t4_done", done, 1);
    checkOutput("t4_no_write", wr_cnt - base, 0);
    pulseLoad();

    $display("[TB] idle timeout inside frame");
    f = '{8'h00, 8'h00, 8'h00};
    sendFrame(f, 3);
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkOutput("t5_err_after_7", err, 0);
    @(negedge clk);
    checkOutput("t5_err_after_8", err, 1);
    doReset();
    repeat (1000) @(posedge clk);
    @(negedge clk);
    checkOutput("t5_idle_addr_hi_err", err, 0);
    checkOutput("t5_idle_addr_hi_ready", bus.rx_ready, 1);

    $display("[TB] reset during DATA_HI");
    base = wr_cnt;
    f = '{8'h00, 8'h20, 8'h00, 8'h01};
    sendFrame(f, 4);
    doReset();
    checkOutput("t6_no_write", wr_cnt - base, 0);
    checkOutput("t6_rx_ready", bus.rx_ready, 1);
    checkOutput("t6_done", done, 0);
    f = '{8'h00, 8'h05, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'hAB, 8'hCD};
    sendFrame(f, 8);
    checkOutput("t6_wr_count", wr_cnt - base, 1);
    checkOutput("t6_wr_addr", wr_addr[base], 16'h0005);
    checkOutput("t6_wr_data", wr_data[base], 16'hABCD);
    checkOutput("t6_done_after", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
